clint: RTL and testbench
========================

CLINT -- requirements
Module: clint

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1, meaning core clock cycles per mtime increment (legal range 1..65535).
REQ-002 The block SHALL have port clk  input  1  the single core clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port clint_we  input  1  write strobe from the data-memory stage (address already decoded to 0x2000000..0x200BFFF).
REQ-005 The block SHALL have port clint_re  input  1  read strobe from the data-memory stage, same decode.
REQ-006 The block SHALL have port Addr  input  64  byte address of the access.
REQ-007 The block SHALL have port MemOP  input  3  access size/sign: [1:0] 3=1B, 2=2B, 1=4B, 0=8B; [2]=sign-extend on read.
REQ-008 The block SHALL have port DataIn  input  64  store data, LSB-aligned.
REQ-009 The block SHALL have port DataOut  output  64  load data, aligned and extended.
REQ-010 The block SHALL have port mtip  output  1  machine timer interrupt pending.
REQ-011 The block SHALL have port msip  output  1  machine software interrupt pending.

Function
REQ-012 Register map SHALL be: msip at 0x2000000 (32-bit, only bit 0 stored, others read 0); mtimecmp at 0x2004000 (64-bit); mtime at 0x200BFF8 (64-bit); selection by Addr[63:3] matching the 8-byte-aligned word containing the register.
REQ-013 A prescaler SHALL count 0..TICK_DIV-1 each cycle and wrap to 0; a tick SHALL occur in the cycle it holds TICK_DIV-1 (with TICK_DIV=1, every cycle).
REQ-014 On a tick mtime SHALL increment by 1 modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF wraps to 0).
REQ-015 Writes SHALL take effect at the rising edge with clint_we=1, using byte mask = size mask (1B 0x01, 2B 0x03, 4B 0x0F, 8B 0xFF) shifted left by Addr[2:0]; lanes shifted past byte 7 SHALL be dropped.
REQ-016 Write data SHALL be DataIn shifted left by 8*Addr[2:0]; only masked bytes of the selected register change.
REQ-017 A write to mtime in a tick cycle SHALL win: written bytes take the written value, unwritten bytes keep their old value, no increment that cycle; the prescaler SHALL continue unaffected.
REQ-018 Reads SHALL be combinational: register word shifted right by 8*Addr[2:0], then truncated to MemOP size and zero- or sign-extended per MemOP[2].
REQ-019 DataOut SHALL be 0 when clint_re=0, or when the address selects no register.
REQ-020 Writes to unmapped addresses SHALL be ignored.
REQ-021 With clint_we and clint_re both 1, DataOut SHALL show the pre-write register value; the write SHALL commit at the edge.
REQ-022 mtip SHALL equal (mtime >= mtimecmp), unsigned 64-bit compare of current register values, combinational from registers.
REQ-023 msip output SHALL equal stored msip bit 0.

Reset
REQ-024 On rst_n low, asynchronously: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip bit=0, prescaler=0; hence mtip=0, msip=0, DataOut=0 (no read).
REQ-025 Reset asserted mid-operation SHALL discard any in-flight write; first increment after release SHALL occur TICK_DIV cycles after the first post-release edge's count start.

Verification
REQ-026 Reset release, TICK_DIV=4, idle 12 cycles -> read 8B at 0x200BFF8 returns 3; mtip=0.
REQ-027 Write 8B 0x10 to 0x2004000, TICK_DIV=1, mtime from 0 -> mtip rises the cycle mtime reaches 0x10, stays 1; writing mtimecmp=0xFFFF_FFFF_FFFF_FFFF clears it next cycle.
REQ-028 Write 1B 0x01 to 0x2000000 -> msip=1; read 4B signed at 0x2000000 returns 0x1; write 0x00 -> msip=0.
REQ-029 Write 4B 0xFFFF_FFFE to 0x200BFFC with mtime low word 5 in a tick cycle -> mtime=0xFFFF_FFFE_0000_0005 exactly, then increments; set mtime=0xFFFF_FFFF_FFFF_FFFF -> next tick mtime=0.
REQ-030 mtimecmp=0x0000_0000_8000_00F0: read 4B at 0x2004000 with MemOP[2]=1 -> 0xFFFF_FFFF_8000_00F0, MemOP[2]=0 -> 0x0000_0000_8000_00F0; read 1B at 0x2004001 unsigned -> 0x00; read at 0x2008000 -> 0.

Source files
------------

// File: rtl/clint.sv
`default_nettype none
// ============================================================================
//  Module   : clint
//  Purpose  : Core-local interruptor. Holds msip, mtimecmp and a free-running
//             mtime counter advanced by a TICK_DIV prescaler. The registers are
//             reached through a byte-addressed load/store port.
//  Ports    : clk, rst_n          - core clock, asynchronous active-low reset
//             clint_we/clint_re   - store/load strobes (address pre-decoded)
//             Addr, MemOP, DataIn - byte address, size/sign code, store data
//             DataOut             - aligned, extended load data
//             mtip, msip          - timer / software interrupt pending
//  Revision : 1.0  initial release
// ============================================================================
module clint #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clint_we,
    input  logic        clint_re,
    input  logic [63:0] Addr,
    input  logic [2:0]  MemOP,
    input  logic [63:0] DataIn,
    output logic [63:0] DataOut,
    output logic        mtip,
    output logic        msip
);

    localparam logic [63:0] MSIP_ADDR     = 64'h0000_0000_0200_0000;
    localparam logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;
    localparam logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
    localparam logic [15:0] PRESC_MAX     = 16'(TICK_DIV - 1);

    logic [15:0] presc_q,    presc_d;
    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q,     msip_d;

    logic        tick;
    logic        sel_msip, sel_cmp, sel_time;
    logic [7:0]  size_mask;
    logic [15:0] lane_mask_wide;
    logic [7:0]  lane_mask;
    logic [63:0] bit_mask;
    logic [63:0] wdata;
    logic [5:0]  shamt;

    assign sel_msip = (Addr[63:3] == MSIP_ADDR[63:3]);
    assign sel_cmp  = (Addr[63:3] == MTIMECMP_ADDR[63:3]);
    assign sel_time = (Addr[63:3] == MTIME_ADDR[63:3]);

    assign tick  = (presc_q == PRESC_MAX);
    assign shamt = {Addr[2:0], 3'b000};

    always_comb begin
        size_mask = 8'hFF;
        case (MemOP[1:0])
            2'd3:    size_mask = 8'h01;
            2'd2:    size_mask = 8'h03;
            2'd1:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Shift in a wider vector so lanes pushed past byte 7 simply fall off.
    assign lane_mask_wide = {8'h00, size_mask} << Addr[2:0];
    assign lane_mask      = lane_mask_wide[7:0];
    assign wdata          = DataIn << shamt;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit_mask
        assign bit_mask[8*gi +: 8] = {8{lane_mask[gi]}};
    end

    // ---------------- next-state ----------------
    always_comb begin
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        // A store to mtime overrides the tick increment for that cycle.
        if (clint_we && sel_time)
            mtime_d = (mtime_q & ~bit_mask) | (wdata & bit_mask);
        else if (tick)
            mtime_d = mtime_q + 64'd1;

        if (clint_we && sel_cmp)
            mtimecmp_d = (mtimecmp_q & ~bit_mask) | (wdata & bit_mask);

        // Only bit 0 of the msip word is implemented.
        if (clint_we && sel_msip && lane_mask[0])
            msip_d = wdata[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
        end
    end

    // ---------------- read path ----------------
    logic [63:0] rd_word;
    logic        rd_hit;
    logic [63:0] rd_shift;
    logic [63:0] rd_ext;

    always_comb begin
        rd_word = 64'd0;
        rd_hit  = 1'b0;
        if (sel_msip) begin
            rd_word = {63'd0, msip_q};
            rd_hit  = 1'b1;
        end else if (sel_cmp) begin
            rd_word = mtimecmp_q;
            rd_hit  = 1'b1;
        end else if (sel_time) begin
            rd_word = mtime_q;
            rd_hit  = 1'b1;
        end
    end

    assign rd_shift = rd_word >> shamt;

    always_comb begin
        rd_ext = rd_shift;
        case (MemOP[1:0])
            2'd3:    rd_ext = {{56{MemOP[2] & rd_shift[7]}},  rd_shift[7:0]};
            2'd2:    rd_ext = {{48{MemOP[2] & rd_shift[15]}}, rd_shift[15:0]};
            2'd1:    rd_ext = {{32{MemOP[2] & rd_shift[31]}}, rd_shift[31:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    assign DataOut = (clint_re && rd_hit) ? rd_ext : 64'd0;
    assign mtip    = (mtime_q >= mtimecmp_q);
    assign msip    = msip_q;

endmodule
`default_nettype wire

// File: tb/tb_clint.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clint
//  Purpose  : Directed self-checking bench for clint. Two instances share one
//             bus: u_dut4 (TICK_DIV=4) and u_dut1 (TICK_DIV=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clint;

    localparam logic [63:0] A_MSIP  = 64'h200_0000;
    localparam logic [63:0] A_CMP   = 64'h200_4000;
    localparam logic [63:0] A_TIME  = 64'h200_BFF8;
    localparam logic [63:0] ALL_F   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [2:0]  memop;
    logic [63:0] din;
    logic [63:0] dout4, dout1;
    logic        mtip4, mtip1, msip4, msip1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] rd;

    clint #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clint_we(we), .clint_re(re), .Addr(addr),
        .MemOP(memop), .DataIn(din), .DataOut(dout4), .mtip(mtip4), .msip(msip4)
    );

    clint #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clint_we(we), .clint_re(re), .Addr(addr),
        .MemOP(memop), .DataIn(din), .DataOut(dout1), .mtip(mtip1), .msip(msip1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [2:0] op, input logic [63:0] d);
        @(negedge clk);
        addr  = a;
        memop = op;
        din   = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    // Samples dut1 half a cycle before the next rising edge.
    task automatic do_read(input logic [63:0] a, input logic [2:0] op, output logic [63:0] d);
        @(negedge clk);
        addr  = a;
        memop = op;
        re    = 1'b1;
        #1;
        d  = dout1;
        re = 1'b0;
    endtask

    initial begin
        we = 0; re = 0; addr = 0; memop = 0; din = 0;
        rst_n = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mtip",  {63'd0, mtip1}, 64'd0);
        check_val("rst_msip",  {63'd0, msip1}, 64'd0);
        check_val("rst_dout",  dout1, 64'd0);
        addr = A_CMP; memop = 3'b000; re = 1'b1;
        #1;
        check_val("rst_cmp_read", dout1, ALL_F);
        re = 1'b0;

        // ---- release, idle 12 cycles ----
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        addr = A_TIME; memop = 3'b000; re = 1'b1;
        #1;
        check_val("div4_mtime_12cyc", dout4, 64'd3);
        check_val("div1_mtime_12cyc", dout1, 64'd12);
        check_val("div4_mtip_idle", {63'd0, mtip4}, 64'd0);
        re = 1'b0;

        // ---- timer compare (TICK_DIV=1) ----
        do_write(A_CMP, 3'b000, 64'h10);
        do_write(A_TIME, 3'b000, 64'h0);
        addr = A_TIME; memop = 3'b000; re = 1'b1;
        check_val("cmp_mtip_k0", {63'd0, mtip1}, 64'd0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("cmp_mtime_k%0d", k), dout1, 64'(k));
            check_val($sformatf("cmp_mtip_k%0d", k), {63'd0, mtip1}, (k >= 16) ? 64'd1 : 64'd0);
        end
        re = 1'b0;
        do_write(A_CMP, 3'b000, ALL_F);
        check_val("cmp_clear_mtip", {63'd0, mtip1}, 64'd0);

        // ---- msip ----
        do_write(A_MSIP, 3'b011, 64'h01);
        check_val("msip_set", {63'd0, msip1}, 64'd1);
        do_read(A_MSIP, 3'b101, rd);
        check_val("msip_read_4bs", rd, 64'h1);
        do_write(A_MSIP, 3'b011, 64'h00);
        check_val("msip_clr", {63'd0, msip1}, 64'd0);
        do_write(A_MSIP + 64'd1, 3'b011, 64'h01);
        check_val("msip_byte1_nochg", {63'd0, msip1}, 64'd0);

        // ---- simultaneous read and write ----
        @(negedge clk);
        addr = A_MSIP; memop = 3'b011; din = 64'h1; we = 1'b1; re = 1'b1;
        #1;
        check_val("rw_pre_value", dout1, 64'd0);
        @(posedge clk);
        #1;
        check_val("rw_post_value", dout1, 64'd1);
        we = 1'b0; re = 1'b0;

        // ---- partial mtime write in a tick cycle ----
        do_write(A_TIME, 3'b000, 64'd5);
        do_write(A_TIME + 64'd4, 3'b001, 64'hFFFF_FFFE);
        do_read(A_TIME, 3'b000, rd);
        check_val("mtime_hi_write", rd, 64'hFFFF_FFFE_0000_0005);
        do_read(A_TIME, 3'b000, rd);
        check_val("mtime_hi_incr", rd, 64'hFFFF_FFFE_0000_0006);

        // ---- mtime wrap (mtimecmp is all ones here) ----
        do_write(A_TIME, 3'b000, ALL_F);
        #1;
        check_val("wrap_mtip_at_max", {63'd0, mtip1}, 64'd1);
        do_read(A_TIME, 3'b000, rd);
        check_val("wrap_max", rd, ALL_F);
        do_read(A_TIME, 3'b000, rd);
        check_val("wrap_zero", rd, 64'd0);
        check_val("wrap_mtip_clear", {63'd0, mtip1}, 64'd0);

        // ---- read sizing / extension ----
        do_write(A_CMP, 3'b000, 64'h0000_0000_8000_00F0);
        do_read(A_CMP, 3'b101, rd);
        check_val("rd_4b_signed", rd, 64'hFFFF_FFFF_8000_00F0);
        do_read(A_CMP, 3'b001, rd);
        check_val("rd_4b_unsigned", rd, 64'h0000_0000_8000_00F0);
        do_read(A_CMP + 64'd1, 3'b011, rd);
        check_val("rd_1b_off1", rd, 64'h0);
        do_read(A_CMP, 3'b111, rd);
        check_val("rd_1b_signed", rd, 64'hFFFF_FFFF_FFFF_FFF0);
        do_read(A_CMP, 3'b010, rd);
        check_val("rd_2b_unsigned", rd, 64'h0000_0000_0000_00F0);
        do_read(64'h200_8000, 3'b000, rd);
        check_val("rd_unmapped", rd, 64'h0);
        @(negedge clk);
        addr = A_CMP; memop = 3'b000; re = 1'b0;
        #1;
        check_val("rd_re_low", dout1, 64'h0);

        // ---- lane drop past byte 7, unmapped write ignored ----
        do_write(A_CMP + 64'd7, 3'b010, 64'hABCD);
        do_read(A_CMP, 3'b000, rd);
        check_val("wr_lane_drop", rd, 64'hCD00_0000_8000_00F0);
        do_write(64'h200_8000, 3'b000, 64'h1234);
        do_read(A_CMP, 3'b000, rd);
        check_val("wr_unmapped_ignored", rd, 64'hCD00_0000_8000_00F0);

        // ---- reset during a write ----
        @(negedge clk);
        addr = A_CMP; memop = 3'b000; din = 64'h0; we = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        we = 1'b0;
        check_val("midrst_msip", {63'd0, msip1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        addr = A_TIME; memop = 3'b000; re = 1'b1;
        #1;
        check_val("midrst_div4_3cyc", dout4, 64'd0);
        @(posedge clk);
        #1;
        check_val("midrst_div4_4cyc", dout4, 64'd1);
        re = 1'b0;
        do_read(A_CMP, 3'b000, rd);
        check_val("midrst_cmp_reset", rd, ALL_F);
        check_val("midrst_mtip", {63'd0, mtip1}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
